count_monitor: RTL and testbench
================================

// Module: count_monitor
// PURPOSE
//  Downstream consumer of the free-running counter's count bus. Samples count
//  each clock, checks that it advances by exactly +1 mod 2^WIDTH, and reports
//  wrap events and sequence errors. Sits beside the counter in the
//  datapath-check logic; outputs feed status registers and self-checking benches.
// PARAMETERS
//  WIDTH      2  width of the monitored count bus
//  CNT_W      8  width of the wrap and error event counters
//  ALLOW_HOLD 0  1: count_in == previous sample is legal (stalled counter)
// PORTS
//  clk         in   1      rising-edge clock, same clock as the counter
//  rst_n       in   1      asynchronous active-low reset
//  count_in    in   WIDTH  registered count from the upstream counter
//  clr         in   1      sync clear of state, counters and sticky error
//  wrap_pulse  out  1      1-cycle pulse: MAX->0 transition seen
//  wrap_cnt    out  CNT_W  wraps seen since reset/clr, saturating
//  err         out  1      sticky: sequence violation seen
//  err_pulse   out  1      1-cycle pulse on the violating sample
//  err_cnt     out  CNT_W  violations seen, saturating
//  state       out  2      FSM state: 00 IDLE, 01 TRACK, 10 ERROR
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, prev=0; all outputs 0 immediately,
//    including in mid-operation. Clean restart on first posedge after release.
//  - All other updates occur on posedge clk. Outputs are registered: latency
//    is 1 cycle from the count_in sample to the wrap_pulse/err_pulse response.
//  - prev <= count_in every cycle except under clr (prev <= 0).
//  - exp = prev + 1, truncated to WIDTH bits (MAX=2^WIDTH-1 wraps to 0).
//  - IDLE: no check on first sample; prev loaded; -> TRACK.
//  - TRACK: count_in==exp -> stay; if prev==MAX, wrap_pulse=1, wrap_cnt++.
//    count_in==prev with ALLOW_HOLD=1 -> stay; no pulse.
//    Any other value -> err_pulse=1, err=1, err_cnt++; -> ERROR.
//  - ERROR: err held at 1. prev keeps resyncing; no further checks, pulses or
//    counting. Exit only via clr or reset.
//  - clr=1: next state IDLE; wrap_cnt, err_cnt, err, both pulses <= 0.
//    clr has priority over a simultaneous wrap or mismatch: no pulse, no count.
//  - Counters saturate at 2^CNT_W-1. They do not roll over.
//  - wrap_pulse and err_pulse are never both 1 in the same cycle.
//  - The ERROR state is mutually exclusive with further wrap counting.
// CONFIGURATION
//  COUNT_MON_CAPTURE_EN defined:
//    adds outputs err_exp[WIDTH-1:0] and err_act[WIDTH-1:0].
//    Both load exp and count_in on the first violation after reset/clr.
//    Both hold until clr or reset, which zero them.
//  COUNT_MON_CAPTURE_EN undefined:
//    err_exp and err_act ports and capture registers are absent.
//    All other behaviour is identical.
// TESTING
//  1. WIDTH=2; reset, then counter 0,1,2,3,0,1,2,3,0 ->
//     wrap_pulse one cycle after each 3->0 sample, wrap_cnt=2, err=0,
//     state=01.
//  2. Sequence 0,1,3 -> err_pulse one cycle after the 3 sample, err=1,
//     err_cnt=1, state=10. Capture on: err_exp=2, err_act=3.
//  3. ALLOW_HOLD=0, sequence 1,1 -> error. ALLOW_HOLD=1, sequence 1,1,2 ->
//     no error, state=01.
//  4. In ERROR, sequence 2,0,3 -> err_cnt stays 1, wrap_cnt unchanged.
//     Then assert clr for 1 cycle -> all counters 0, err=0, state=00,
//     then 01 on the next sample.
//  5. clr together with a 3->0 wrap or a bad value ->
//     wrap_pulse=0, err_pulse=0, both counts 0.
//  6. rst_n low asynchronously mid-count (between edges) -> outputs 0 before
//     the next edge. After release, first sample is not checked (any value
//     accepted).
//  7. CNT_W=2, 5 wraps -> wrap_cnt saturates at 3.

Source files
------------

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - checks that count_in advances by +1 mod 2^WIDTH, reports wraps and errors
// Optional capture of expected/actual values on the first violation: COUNT_MON_CAPTURE_EN
module count_monitor #(
   parameter int WIDTH      = 2,
   parameter int CNT_W      = 8,
   parameter int ALLOW_HOLD = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] count_in,
   input  logic             clr,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic             err,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       state
`ifdef COUNT_MON_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] err_exp,
   output logic [WIDTH-1:0] err_act
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      TRACK = 2'b01,
      ERROR = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           cur;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] exp_val;
   logic             is_next;
   logic             is_hold;

   assign exp_val = prev + WIDTH'(1);
   assign is_next = (count_in == exp_val);
   assign is_hold = (ALLOW_HOLD != 0) && (count_in == prev);
   assign state   = cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur        <= IDLE;
         prev       <= '0;
         wrap_pulse <= 1'b0;
         wrap_cnt   <= '0;
         err        <= 1'b0;
         err_pulse  <= 1'b0;
         err_cnt    <= '0;
`ifdef COUNT_MON_CAPTURE_EN
         err_exp    <= '0;
         err_act    <= '0;
`endif
      end else if (clr) begin
         // clr wins over any wrap or mismatch seen on the same sample
         cur        <= IDLE;
         prev       <= '0;
         wrap_pulse <= 1'b0;
         wrap_cnt   <= '0;
         err        <= 1'b0;
         err_pulse  <= 1'b0;
         err_cnt    <= '0;
`ifdef COUNT_MON_CAPTURE_EN
         err_exp    <= '0;
         err_act    <= '0;
`endif
      end else begin
         prev       <= count_in;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         case (cur)
            IDLE: cur <= TRACK;
            TRACK: begin
               if (is_next) begin
                  if (prev == MAX) begin
                     wrap_pulse <= 1'b1;
                     if (wrap_cnt != CNT_MAX) wrap_cnt <= wrap_cnt + CNT_W'(1);
                  end
               end else if (!is_hold) begin
                  // TRACK is left for good, so this is always the first violation
                  err_pulse <= 1'b1;
                  err       <= 1'b1;
                  if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                  cur       <= ERROR;
`ifdef COUNT_MON_CAPTURE_EN
                  err_exp   <= exp_val;
                  err_act   <= count_in;
`endif
               end
            end
            ERROR: cur <= ERROR;
            default: cur <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - scoreboard bench for count_monitor (three parameterisations)
module tb_count_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] count_in = 2'd0;
   logic       clr = 1'b0;

   always #5 clk = ~clk;

   logic       wrap_pulse, err, err_pulse;
   logic [7:0] wrap_cnt, err_cnt;
   logic [1:0] state;
`ifdef COUNT_MON_CAPTURE_EN
   logic [1:0] err_exp, err_act;
   logic [1:0] h_err_exp, h_err_act, s_err_exp, s_err_act;
`endif
   logic       h_wrap_pulse, h_err, h_err_pulse;
   logic [7:0] h_wrap_cnt, h_err_cnt;
   logic [1:0] h_state;
   logic       s_wrap_pulse, s_err, s_err_pulse;
   logic [1:0] s_wrap_cnt, s_err_cnt;
   logic [1:0] s_state;

   count_monitor #(.WIDTH(2), .CNT_W(8), .ALLOW_HOLD(0)) dut (
      .clk(clk), .rst_n(rst_n), .count_in(count_in), .clr(clr),
      .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .err(err),
      .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
`ifdef COUNT_MON_CAPTURE_EN
      , .err_exp(err_exp), .err_act(err_act)
`endif
   );

   count_monitor #(.WIDTH(2), .CNT_W(8), .ALLOW_HOLD(1)) dut_h (
      .clk(clk), .rst_n(rst_n), .count_in(count_in), .clr(clr),
      .wrap_pulse(h_wrap_pulse), .wrap_cnt(h_wrap_cnt), .err(h_err),
      .err_pulse(h_err_pulse), .err_cnt(h_err_cnt), .state(h_state)
`ifdef COUNT_MON_CAPTURE_EN
      , .err_exp(h_err_exp), .err_act(h_err_act)
`endif
   );

   count_monitor #(.WIDTH(2), .CNT_W(2), .ALLOW_HOLD(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .count_in(count_in), .clr(clr),
      .wrap_pulse(s_wrap_pulse), .wrap_cnt(s_wrap_cnt), .err(s_err),
      .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .state(s_state)
`ifdef COUNT_MON_CAPTURE_EN
      , .err_exp(s_err_exp), .err_act(s_err_act)
`endif
   );

   typedef struct packed {
      logic       wp;
      logic       ep;
      logic       er;
      logic [7:0] wc;
      logic [7:0] ec;
      logic [1:0] st;
   } obs_t;

   obs_t       sb_q[$];
   logic [3:0] cap_q[$];
   int         errors = 0;
   int         checks = 0;

   // reference model of the WIDTH=2, CNT_W=8, ALLOW_HOLD=0 instance
   logic [1:0] m_state, m_prev, m_xe, m_xa;
   logic [7:0] m_wc, m_ec;
   logic       m_err, m_wp, m_ep;

   task automatic model_reset();
      m_state = 2'b00; m_prev = 2'd0; m_wc = 8'd0; m_ec = 8'd0;
      m_err = 1'b0; m_wp = 1'b0; m_ep = 1'b0; m_xe = 2'd0; m_xa = 2'd0;
   endtask

   task automatic model_step(input logic [1:0] v, input logic c);
      logic [1:0] nxt;
      nxt = m_prev + 2'd1;
      m_wp = 1'b0;
      m_ep = 1'b0;
      if (c) begin
         model_reset();
      end else begin
         if (m_state == 2'b00) begin
            m_state = 2'b01;
         end else if (m_state == 2'b01) begin
            if (v == nxt) begin
               if (m_prev == 2'd3) begin
                  m_wp = 1'b1;
                  if (m_wc != 8'hFF) m_wc = m_wc + 8'd1;
               end
            end else begin
               m_ep = 1'b1; m_err = 1'b1; m_state = 2'b10;
               if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
               m_xe = nxt; m_xa = v;
            end
         end
         m_prev = v;
      end
      sb_q.push_back('{m_wp, m_ep, m_err, m_wc, m_ec, m_state});
      cap_q.push_back({m_xe, m_xa});
   endtask

   task automatic check_main(input string tag);
      obs_t e, a;
      logic [3:0] ec;
      if (sb_q.size() == 0) begin
         errors++; checks++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sb_q.pop_front();
      ec = cap_q.pop_front();
      a = '{wrap_pulse, err_pulse, err, wrap_cnt, err_cnt, state};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got wp=%b ep=%b err=%b wc=%0d ec=%0d st=%b, expected wp=%b ep=%b err=%b wc=%0d ec=%0d st=%b",
                  tag, a.wp, a.ep, a.er, a.wc, a.ec, a.st, e.wp, e.ep, e.er, e.wc, e.ec, e.st);
      end
`ifdef COUNT_MON_CAPTURE_EN
      checks++;
      if ({err_exp, err_act} !== ec) begin
         errors++;
         $display("FAIL %s capture: got exp=%0d act=%0d, expected exp=%0d act=%0d",
                  tag, err_exp, err_act, ec[3:2], ec[1:0]);
      end
`else
      if (ec === 4'bxxxx) $display("note: capture model undefined");
`endif
   endtask

   task automatic cycle(input logic [1:0] v, input logic c, input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      count_in = v;
      clr = c;
      model_step(v, c);
      @(posedge clk);
      #1;
      check_main(tag);
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      checks++;
      if ({wrap_pulse, err_pulse, err, wrap_cnt, err_cnt, state} !== 21'd0) begin
         errors++;
         $display("FAIL reset: got outputs %h, expected 0",
                  {wrap_pulse, err_pulse, err, wrap_cnt, err_cnt, state});
      end
   endtask

   task automatic test_wrap();
      logic [1:0] seq [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      foreach (seq[i]) cycle(seq[i], 1'b0, "wrap");
      checks++;
      if (wrap_cnt !== 8'd2 || err !== 1'b0 || state !== 2'b01) begin
         errors++;
         $display("FAIL wrap_final: got wc=%0d err=%b st=%b, expected wc=2 err=0 st=01", wrap_cnt, err, state);
      end
   endtask

   task automatic test_error();
      cycle(2'd0, 1'b1, "err_clr");
      cycle(2'd0, 1'b0, "err");
      cycle(2'd1, 1'b0, "err");
      cycle(2'd3, 1'b0, "err");
      checks++;
      if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || state !== 2'b10) begin
         errors++;
         $display("FAIL err_final: got ep=%b ec=%0d st=%b, expected ep=1 ec=1 st=10", err_pulse, err_cnt, state);
      end
`ifdef COUNT_MON_CAPTURE_EN
      checks++;
      if (err_exp !== 2'd2 || err_act !== 2'd3) begin
         errors++;
         $display("FAIL err_capture: got exp=%0d act=%0d, expected exp=2 act=3", err_exp, err_act);
      end
`endif
   endtask

   task automatic test_error_hold_and_clr();
      cycle(2'd2, 1'b0, "in_error");
      cycle(2'd0, 1'b0, "in_error");
      cycle(2'd3, 1'b0, "in_error");
      cycle(2'd1, 1'b1, "error_clr");
      cycle(2'd2, 1'b0, "after_clr");
   endtask

   task automatic test_hold();
      cycle(2'd0, 1'b1, "hold_clr");
      cycle(2'd1, 1'b0, "hold");
      cycle(2'd1, 1'b0, "hold");
      cycle(2'd2, 1'b0, "hold");
      checks++;
      if (h_err !== 1'b0 || h_err_cnt !== 8'd0 || h_state !== 2'b01) begin
         errors++;
         $display("FAIL hold_allowed: got err=%b ec=%0d st=%b, expected err=0 ec=0 st=01", h_err, h_err_cnt, h_state);
      end
   endtask

   task automatic test_clr_priority();
      cycle(2'd0, 1'b1, "prio_clr");
      cycle(2'd2, 1'b0, "prio");
      cycle(2'd3, 1'b0, "prio");
      cycle(2'd0, 1'b1, "prio_wrap_clr");
      cycle(2'd0, 1'b0, "prio");
      cycle(2'd1, 1'b0, "prio");
      cycle(2'd3, 1'b1, "prio_bad_clr");
   endtask

   task automatic test_async_reset();
      cycle(2'd0, 1'b0, "pre_rst");
      cycle(2'd1, 1'b0, "pre_rst");
      cycle(2'd2, 1'b0, "pre_rst");
      cycle(2'd0, 1'b0, "pre_rst");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({wrap_pulse, err_pulse, err, wrap_cnt, err_cnt, state} !== 21'd0) begin
         errors++;
         $display("FAIL async_reset: got outputs %h, expected 0",
                  {wrap_pulse, err_pulse, err, wrap_cnt, err_cnt, state});
      end
      cycle(2'd2, 1'b0, "post_rst");
      cycle(2'd3, 1'b0, "post_rst");
      cycle(2'd0, 1'b0, "post_rst");
   endtask

   task automatic test_saturate();
      cycle(2'd0, 1'b1, "sat_clr");
      cycle(2'd0, 1'b0, "sat");
      for (int w = 0; w < 5; w++) begin
         cycle(2'd1, 1'b0, "sat");
         cycle(2'd2, 1'b0, "sat");
         cycle(2'd3, 1'b0, "sat");
         cycle(2'd0, 1'b0, "sat");
      end
      checks++;
      if (s_wrap_cnt !== 2'd3 || s_state !== 2'b01) begin
         errors++;
         $display("FAIL saturate: got wc=%0d st=%b, expected wc=3 st=01", s_wrap_cnt, s_state);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_error();
      test_error_hold_and_clr();
      test_hold();
      test_clr_priority();
      test_async_reset();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
